// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle DECODE/EXEC/MEM/WB control unit for the regfile/ALU/RAM datapath.
// Define SEQ_COND_EXEC_EN to gate RAM/register writes and flag updates on a COND predicate over the flags.
module datapath_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int FLAG_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [FLAG_W-1:0] alu_signal,
    output logic [4:0]        A,
    output logic [4:0]        B,
    output logic [4:0]        regSel,
    output logic [4:0]        FS,
    output logic              CO,
    output logic              muxSelect,
    output logic              wrt,
    output logic              RAMwrt,
    output logic [FLAG_W-1:0] flags,
    output logic              busy,
    output logic              done
);
    localparam int LAT = (MEM_LAT < 1) ? 1 : MEM_LAT;
    localparam logic [3:0] LAST = 4'(LAT - 1);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    state_t      state, next;
    logic [31:0] ir;
    logic [3:0]  cnt;
    logic        pred;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    // Control word latch, MEM dwell counter and status flag register
    always_ff @(posedge clock) begin
        if (!reset) begin
            ir    <= '0;
            cnt   <= '0;
            flags <= '0;
        end else begin
            if (state == IDLE && instr_valid) ir <= instr;
            cnt <= (state == MEM) ? cnt + 4'd1 : 4'd0;
            if (state == EXEC && ir[24] && pred) flags <= alu_signal;
        end
    end

`ifdef SEQ_COND_EXEC_EN
    logic [7:0] cond_tbl;
    logic       unused_bits;
    assign cond_tbl    = {1'b0, flags[3], flags[2], ~flags[1], flags[1], ~flags[0], flags[0], 1'b1};
    assign unused_bits = ^ir[31:28];

    // Predicate captured in DECODE so it sees the flags before this op's own update
    always_ff @(posedge clock) begin
        if (!reset)                pred <= 1'b1;
        else if (state == DECODE)  pred <= cond_tbl[ir[27:25]];
    end
`else
    logic unused_bits;
    assign pred        = 1'b1;
    assign unused_bits = ^ir[31:25];
`endif

    // Next-state sequencing and datapath control decode
    always_comb begin
        next        = state;
        busy        = (state != IDLE);
        instr_ready = (state == IDLE);
        A           = busy ? ir[9:5]   : 5'd0;
        B           = busy ? ir[14:10] : 5'd0;
        regSel      = busy ? ir[4:0]   : 5'd0;
        FS          = busy ? ir[19:15] : 5'd0;
        CO          = busy & ir[23];
        muxSelect   = busy & ir[22];
        wrt         = 1'b0;
        RAMwrt      = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:    next = instr_valid ? DECODE : IDLE;
            DECODE:  next = EXEC;
            EXEC:    next = MEM;
            MEM: begin
                RAMwrt = (cnt == 4'd0) && ir[21] && pred;
                next   = (cnt == LAST) ? WB : MEM;
            end
            WB: begin
                wrt  = ir[20] && pred;
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: randomized scoreboard bench for datapath_sequencer against an operation-level model.
module tb_datapath_sequencer;
    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [3:0]  alu_signal = '0;
    logic        instr_ready, CO, muxSelect, wrt, RAMwrt, busy, done;
    logic [4:0]  A, B, regSel, FS;
    logic [3:0]  flags;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] a, b, rs, fs;
        logic       co, ms, wrt, ramw;
        logic [3:0] flags;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model_flags = '0;

    datapath_sequencer #(.MEM_LAT(LAT), .FLAG_W(4)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_signal(alu_signal), .A(A), .B(B), .regSel(regSel),
        .FS(FS), .CO(CO), .muxSelect(muxSelect), .wrt(wrt), .RAMwrt(RAMwrt), .flags(flags),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, want);
    endtask

    // Conditional-execution predicate from the COND encoding table
    function automatic logic cond_ok(input logic [2:0] c, input logic [3:0] f);
`ifdef SEQ_COND_EXEC_EN
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[0];
            3'd2:    return !f[0];
            3'd3:    return f[1];
            3'd4:    return !f[1];
            3'd5:    return f[2];
            3'd6:    return f[3];
            default: return 1'b0;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] mk(input int da, input int sa, input int sbs, input int fs,
                                       input int rw, input int mw, input int ms, input int ci,
                                       input int sf, input int cond);
        logic [31:0] w;
        w = $urandom;
        w[4:0] = da[4:0];
        w[9:5] = sa[4:0];
        w[14:10] = sbs[4:0];
        w[19:15] = fs[4:0];
        w[20] = rw[0];
        w[21] = mw[0];
        w[22] = ms[0];
        w[23] = ci[0];
        w[24] = sf[0];
        w[27:25] = cond[2:0];
        return w;
    endfunction

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Issue one op: wait for ready, push the expected outcome, then present the EXEC-cycle ALU status
    task automatic issue(input logic [31:0] w, input logic [3:0] ex);
        exp_t e;
        logic p;
        int   t = 0;
        while (!instr_ready && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (!instr_ready) begin
            check("ready_timeout", instr_ready, 1);
            return;
        end
        p = cond_ok(w[27:25], model_flags);
        e.a = w[9:5];
        e.b = w[14:10];
        e.rs = w[4:0];
        e.fs = w[19:15];
        e.co = w[23];
        e.ms = w[22];
        e.wrt = w[20] && p;
        e.ramw = w[21] && p;
        e.flags = (w[24] && p) ? ex : model_flags;
        e.acc = cyc + 1;
        model_flags = e.flags;
        sb.push_back(e);
        instr = w;
        instr_valid = 1'b1;
        alu_signal = 4'($urandom);
        @(negedge clock);
        instr = $urandom;
        instr_valid = 1'($urandom);
        alu_signal = 4'($urandom);
        @(negedge clock);
        alu_signal = ex;
        @(negedge clock);
        alu_signal = 4'($urandom);
        instr = $urandom;
        instr_valid = 1'($urandom);
    endtask

    // Monitor: per-cycle output checks, pops the scoreboard when done is presented
    initial begin
        exp_t e;
        int   ram_cnt = 0;
        bit   ready_due = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                ram_cnt = 0;
                ready_due = 1'b0;
            end else begin
                if (ready_due) check("ready_after_done", instr_ready, 1);
                ready_due = 1'b0;
                check("ready_vs_busy", instr_ready, !busy);
                check("wrt_ramwrt_overlap", wrt & RAMwrt, 0);
                if (!busy) begin
                    check("idle_outputs", {A, B, regSel, FS, CO, muxSelect, wrt, RAMwrt, done}, 0);
                end else if (sb.size() == 0) begin
                    check("busy_without_op", busy, 0);
                end else begin
                    e = sb[0];
                    check("selects", {A, B, regSel, FS, CO, muxSelect},
                          {e.a, e.b, e.rs, e.fs, e.co, e.ms});
                    check("wrt_outside_wb", wrt & !done, 0);
                    if (RAMwrt) begin
                        ram_cnt++;
                        check("ramwrt_cycle", cyc, e.acc + 2);
                    end
                    if (done) begin
                        check("done_cycle", cyc, e.acc + 2 + LAT);
                        check("wrt", wrt, e.wrt);
                        check("ramwrt_count", ram_cnt, e.ramw);
                        check("flags", flags, e.flags);
                        void'(sb.pop_front());
                        ram_cnt = 0;
                        ready_due = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clock);
        check("rst_ready", instr_ready, 1);
        check("rst_flags", flags, 0);
        check("rst_outputs", {A, B, regSel, FS, CO, muxSelect, wrt, RAMwrt, done, busy}, 0);
        reset = 1'b1;
        @(negedge clock);
        issue(mk(3, 1, 2, 5, 1, 0, 0, 0, 0, 0), 4'h0);
        idle(2);
        issue(mk(7, 4, 9, 2, 0, 1, 0, 1, 0, 0), 4'h0);
        issue(mk(8, 6, 0, 0, 1, 0, 1, 0, 0, 0), 4'h0);
        issue(mk(1, 2, 3, 4, 1, 0, 0, 0, 1, 0), 4'b0101);
        issue(mk(1, 2, 3, 4, 1, 0, 0, 0, 0, 0), 4'b1111);
        issue(mk(2, 2, 2, 2, 1, 0, 0, 0, 1, 0), 4'b0000);
        issue(mk(5, 5, 5, 5, 1, 0, 0, 0, 0, 1), 4'hf);
        issue(mk(5, 5, 5, 5, 1, 0, 0, 0, 0, 2), 4'hf);
        issue(mk(6, 7, 8, 9, 1, 1, 0, 0, 1, 7), 4'hf);
        for (int i = 0; i < 40; i++) begin
            issue(mk($urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                     $urandom_range(31, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                     $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                     $urandom_range(7, 0)), 4'($urandom));
            if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 0));
        end
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("drain", sb.size(), 0);
        issue(mk(9, 1, 1, 1, 1, 1, 0, 0, 1, 0), 4'b1010);
        reset = 1'b0;
        sb.delete();
        model_flags = '0;
        repeat (2) @(negedge clock);
        check("midop_rst_ready", instr_ready, 1);
        check("midop_rst_flags", flags, 0);
        check("midop_rst_outputs", {A, B, regSel, FS, CO, muxSelect, wrt, RAMwrt, done, busy}, 0);
        reset = 1'b1;
        instr_valid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            check("post_rst_quiet", {wrt, RAMwrt, done, busy}, 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control unit for the register-file / ALU / RAM datapath. Accepts one 32-bit control word per operation over a valid/ready handshake. Steps the datapath through DECODE, EXEC, MEM and WB, driving the register selects, the ALU function select, the carry-in, the RAM write, the result mux and the register write. Latches the ALU status flags into a flag register. Sits between the instruction source (bench or future fetch unit) and the datapath top level.

Parameters:
MEM_LAT, 1, cycles spent in MEM state (1..15); covers RAM read latency when the result mux selects RAM
FLAG_W, 4, width of the ALU status vector (V,C,N,Z order: [3]=V [2]=C [1]=N [0]=Z)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
instr  in  32  control word: [4:0] DA, [9:5] SA, [14:10] SB, [19:15] FS, [20] RW, [21] MW, [22] MS, [23] CI, [24] SF, [27:25] COND, [31:28] reserved (ignored)
instr_valid  in  1  instr is valid
instr_ready  out  1  sequencer can accept instr
alu_signal  in  FLAG_W  ALU status from datapath
A  out  5  register read select A (SA)
B  out  5  register read select B (SB)
regSel  out  5  register write select (DA)
FS  out  5  ALU function select
CO  out  1  ALU carry-in
muxSelect  out  1  writeback source: 0 ALU, 1 RAM
wrt  out  1  register-file write enable
RAMwrt  out  1  RAM write enable
flags  out  FLAG_W  latched status flags
busy  out  1  operation in progress
done  out  1  single-cycle completion pulse

Behaviour:
- States: IDLE, DECODE, EXEC, MEM, WB. Reset (reset==0 at a rising edge) forces IDLE, mem counter 0. All outputs 0 except instr_ready=1; flags=0. Applies mid-operation: any pending wrt/RAMwrt is dropped the same edge.
- IDLE: instr_ready=1, busy=0. Handshake when instr_valid && instr_ready at edge N. instr latched, go to DECODE.
- instr_ready=0 in every non-IDLE state. instr_valid ignored there; instr changes ignored after the latch.
- DECODE (cycle N+1): A, B, regSel, FS, CO, muxSelect driven from the latched word. They hold constant through WB and return to 0 in IDLE. wrt=RAMwrt=0.
- EXEC (N+2): ALU settles. At the end-of-EXEC edge, flags<=alu_signal if SF=1, else flags are unchanged.
- MEM (N+3 .. N+2+MEM_LAT): RAMwrt=1 during the first MEM cycle only, and only if MW=1. The counter runs MEM_LAT cycles, then goes to WB.
- WB (N+3+MEM_LAT): wrt=1 for exactly this cycle if RW=1. done=1 this cycle. Next state IDLE. instr_ready=1 at N+4+MEM_LAT.
- busy=1 in DECODE..WB.
- Throughput: one operation per 4+MEM_LAT cycles. No overlap between operations.
- wrt and RAMwrt are never both asserted in the same cycle, and neither is asserted outside MEM/WB.
- MEM_LAT=0 is illegal. Implementation clamps it to 1.

Optional Feature:
SEQ_COND_EXEC_EN
- Defined: COND selects a predicate on the current flags (the value before this op's SF update), evaluated in DECODE.
  - COND encoding: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 V, 111 never.
  - Predicate false: RAMwrt and wrt are suppressed, flags are not updated, and the state sequence and done timing are unchanged.
- Not defined: COND is ignored and every op executes unconditionally.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-WB with RW=1 -> wrt=0 at that edge onward; instr_ready=1, flags=0, all selects 0.
- ALU op, MEM_LAT=1: instr DA=3 SA=1 SB=2 FS=5 RW=1, valid at edge 0 -> A=1 B=2 FS=5 regSel=3 from cycle 1; wrt=1 and done=1 only in cycle 4; instr_ready=1 in cycle 5.
- RAM store then load, MEM_LAT=3: store MW=1 RW=0 -> RAMwrt=1 exactly 1 cycle (cycle 3), wrt never asserted. Load MS=1 RW=1 -> muxSelect=1 held cycles 1-6, wrt in cycle 6.
- Flags: SF=1 with alu_signal=4'b0101 in EXEC -> flags=0101 after EXEC. Next op SF=0 with alu_signal=4'b1111 -> flags stay 0101.
- Handshake: instr_valid held high continuously, instr changed while busy -> exactly one accept per 5 cycles (MEM_LAT=1); mid-op instr changes have no effect.
- SEQ_COND_EXEC_EN: flags Z=0, COND=001, RW=1 -> wrt=0 and done=1 in cycle 4. COND=010 -> wrt=1.
